vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
- Generates 640x480@60 Hz VGA raster timing (hsync, vsync) from the 25 MHz pixel clock.
- Issues pixel coordinates (pos_x, pos_y) one cycle ahead of the visible pixel. This covers the 1-cycle read latency of the block-RAM sprite renderers.
- Samples their 24-bit pos_data return and drives the board's 12-bit RGB pins, aligned with sync and data-enable.
- Sits between the top-level VGA pins and all pixel-source blocks (notes display, keyboard, score overlays). Also provides a frame tick for game/animation logic.

Parameters:
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch
H_VALID, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch
V_VALID, 480, visible lines
V_FRONT, 10, vertical front porch

Ports:
vga_clk  in  1  pixel clock, 25 MHz
rst  in  1  asynchronous reset, active-high
pos_data  in  24  pixel colour from renderers, {R[23:16],G[15:8],B[7:0]}
pos_x  out  10  requested pixel column, 0..639; 0 when pix_req=0
pos_y  out  10  requested pixel row, 0..479; 0 when pix_req=0
pix_req  out  1  pos_x/pos_y valid this cycle
hsync  out  1  horizontal sync, active-low, registered
vsync  out  1  vertical sync, active-low, registered
de  out  1  visible-pixel data enable, registered
rgb  out  12  {R[3:0],G[3:0],B[3:0]} to VGA DAC, registered
frame_start  out  1  one-cycle pulse, registered

Behaviour:
- Interface: one clock, vga_clk; reset rst is asynchronous and active-high.
- Totals: H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- Horizontal counter cnt_h:
  - Counts 0..H_TOTAL-1 and wraps to 0.
- Vertical counter cnt_v:
  - Increments only when cnt_h = H_TOTAL-1.
  - Wraps to 0 when cnt_v = V_TOTAL-1 coincides with cnt_h = H_TOTAL-1.
- Region definitions:
  - HA = H_SYNC+H_BACK (144); VA = V_SYNC+V_BACK (35).
  - Active line: VA <= cnt_v < VA+V_VALID.
  - Visible pixel: active line and HA <= cnt_h < HA+H_VALID.
- Request (combinational from counters):
  - pix_req = 1 when active line and HA-1 <= cnt_h <= HA+H_VALID-2, i.e. one cycle ahead of visible.
  - When pix_req=1: pos_x = cnt_h-(HA-1), pos_y = cnt_v-VA. Otherwise both are 0.
  - Subtraction is 10-bit; no negative values are reachable while pix_req=1.
- Latency contract: pos_data received in the cycle with cnt_h = HA+k carries pixel k of the current line. The renderer responds to the previous cycle's request.
- Output register stage, all outputs updated on the same edge:
  - hsync <= (cnt_h >= H_SYNC)
  - vsync <= (cnt_v >= V_SYNC)
  - de <= visible
  - rgb <= visible ? {pos_data[23:20],pos_data[15:12],pos_data[7:4]} : 12'h000
  - frame_start <= (cnt_h==0 && cnt_v==0)
- Net effect: all pin outputs lag the counters by exactly 1 cycle and are mutually aligned.
- Colour conversion is truncation (upper nibble of each channel), no rounding.
- Blanking:
  - rgb is forced to 0 whenever de=0, regardless of pos_data. This includes the request-lead cycle cnt_h = HA-1.
  - pos_data is ignored outside visible cycles.
- Reset, asynchronous, effective immediately without a clock edge:
  - cnt_h=0, cnt_v=0.
  - hsync=1, vsync=1, de=0, rgb=0, frame_start=0.
  - pix_req=0, pos_x=0, pos_y=0.
- After reset release:
  - First edge: counting starts from cnt_h=0.
  - First edge: hsync/vsync go 0 (sync region) and frame_start pulses.
- Reset mid-line or mid-frame: abandons the frame; no partial state is retained.
- Frame period: H_TOTAL*V_TOTAL = 420000 cycles. frame_start asserts exactly once per frame.

Test Plan:
- Reset check: assert rst mid-frame at cnt_h=400, no clock edge. All outputs take their reset values immediately, incl. hsync=1, vsync=1, rgb=0, pos_x=0. Release: first edge gives hsync=0, vsync=0, frame_start=1.
- Line timing: measure hsync over 3 lines. Low for 96 cycles, period 800. vsync low for 1600 cycles, period 420000.
- Request sequence, first active line (cnt_v=35):
  - cnt_h=143: pix_req=1, pos_x=0, pos_y=0.
  - cnt_h=782: pos_x=639.
  - cnt_h=783: pix_req=0, pos_x=0.
  - Last active line (cnt_v=514): pos_y=479.
- Colour pipeline:
  - Drive pos_data=24'hFF8010 at cnt_h=144, cnt_v=35 → next cycle rgb=12'hF81, de=1.
  - Drive pos_data=24'hFFFFFF during cnt_h=143 and cnt_h=784 → rgb=0, de=0.
- Model cross-check: run 2 full frames against a reference model emitting pixel colour = f(pos_x,pos_y) with 1-cycle latency. Every de=1 cycle shows the expected rgb. de=1 count per frame is 307200.
- Frame tick: frame_start pulses exactly twice in 840000 cycles after reset release, 420000 cycles apart, each pulse 1 cycle wide.

Source files
------------

// File: rtl/vga_timing_ctrl_if.sv
// Bundle of the pixel request/return bus and the registered VGA pin outputs.
// The timing controller drives through the master modport; the pixel sources
// and the pin pads see the slave view.
interface vga_timing_ctrl_if;
    logic [23:0] pos_data;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        pix_req;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] rgb;
    logic        frame_start;

    modport master (
        input  pos_data,
        output pos_x, pos_y, pix_req,
        output hsync, vsync, de, rgb, frame_start
    );

    modport slave (
        output pos_data,
        input  pos_x, pos_y, pix_req,
        input  hsync, vsync, de, rgb, frame_start
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 Hz VGA raster timing generator. Requests pixel coordinates one
// cycle ahead of the visible pixel so block-RAM renderers can answer in time,
// then registers sync, data-enable and the truncated 12-bit colour together.
module vga_timing_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic              vga_clk,
    input  logic              rst,
    vga_timing_ctrl_if.master bus
);

    localparam int H_TOTAL_I = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL_I = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HA_I      = H_SYNC + H_BACK;
    localparam int VA_I      = V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL_I - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL_I - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_START = 10'(HA_I);
    localparam logic [9:0] H_VIS_END   = 10'(HA_I + H_VALID);
    localparam logic [9:0] V_VIS_START = 10'(VA_I);
    localparam logic [9:0] V_VIS_END   = 10'(VA_I + V_VALID);
    localparam logic [9:0] REQ_START   = 10'(HA_I - 1);
    localparam logic [9:0] REQ_END     = 10'(HA_I + H_VALID - 2);

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       active_line;
    logic       visible;
    logic       req;

    // Raster position: cnt_h sweeps each line, cnt_v steps once per completed line.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (cnt_h == H_LAST) begin
            cnt_h <= '0;
            if (cnt_v == V_LAST) begin
                cnt_v <= '0;
            end else begin
                cnt_v <= cnt_v + 10'd1;
            end
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    // Region decode and the coordinate request, which leads the visible window by one column.
    always_comb begin
        active_line = (cnt_v >= V_VIS_START) && (cnt_v < V_VIS_END);
        visible     = active_line && (cnt_h >= H_VIS_START) && (cnt_h < H_VIS_END);
        req         = active_line && (cnt_h >= REQ_START) && (cnt_h <= REQ_END);
        bus.pix_req = req;
        bus.pos_x   = req ? (cnt_h - REQ_START) : 10'd0;
        bus.pos_y   = req ? (cnt_v - V_VIS_START) : 10'd0;
    end

    // Pin register: every output is taken from the same counter state so they stay mutually aligned.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.de          <= 1'b0;
            bus.rgb         <= 12'h000;
            bus.frame_start <= 1'b0;
        end else begin
            bus.hsync       <= (cnt_h >= H_SYNC_END);
            bus.vsync       <= (cnt_v >= V_SYNC_END);
            bus.de          <= visible;
            bus.rgb         <= visible ? {bus.pos_data[23:20], bus.pos_data[15:12], bus.pos_data[7:4]}
                                       : 12'h000;
            bus.frame_start <= (cnt_h == 10'd0) && (cnt_v == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance covers reset, line timing and
// the first active line; a shrunken instance covers whole frames. A renderer
// with one-cycle latency answers each request with a keyed colour pattern.
module tb_vga_timing_ctrl;

    typedef struct packed {
        int hs; int hb; int hv; int hf;
        int vs; int vb; int vv; int vf;
    } geom_t;

    typedef struct packed {
        logic       req;
        logic [9:0] x;
        logic [9:0] y;
    } req_t;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [11:0] rgb;
        logic        fs;
    } pins_t;

    localparam geom_t GB = '{hs:96, hb:48, hv:640, hf:16, vs:2, vb:33, vv:480, vf:10};
    localparam geom_t GS = '{hs:8, hb:4, hv:32, hf:4, vs:2, vb:3, vv:20, vf:2};
    localparam int LINE_B  = 800;
    localparam int LINE_S  = 48;
    localparam int FRAME_S = 48 * 27;
    localparam int ROW35   = 35 * LINE_B;

    logic clk = 1'b0;
    logic rst;

    vga_timing_ctrl_if bus_b ();
    vga_timing_ctrl_if bus_s ();

    vga_timing_ctrl dut_b (
        .vga_clk (clk),
        .rst     (rst),
        .bus     (bus_b)
    );

    vga_timing_ctrl #(
        .H_SYNC (8), .H_BACK (4), .H_VALID (32), .H_FRONT (4),
        .V_SYNC (2), .V_BACK (3), .V_VALID (20), .V_FRONT (2)
    ) dut_s (
        .vga_clk (clk),
        .rst     (rst),
        .bus     (bus_s)
    );

    always #20 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int phase = 0;

    logic [23:0] key_b;
    logic [23:0] key_s;
    logic        ovr_b;
    logic [23:0] ovr_val_b;

    logic prev_hs_b, prev_vs_b, prev_vs_s;
    int   last_hfall, n_hfall, n_hrise;
    int   last_vfall_b, n_vrise_b;
    int   last_vfall_s, n_vfall_s, n_vrise_s;
    int   fs_cnt;
    int   fs_times[$];
    int   de_cnt[2];

    // Renderer pattern: any function of (x, y) works; the key varies it per run.
    function automatic logic [23:0] colour(int x, int y, logic [23:0] key);
        return {8'(x) ^ key[23:16], 8'(y * 3) ^ key[15:8], 8'(x + y) ^ key[7:0]};
    endfunction

    function automatic logic [11:0] nibbles(logic [23:0] p);
        return {p[23:20], p[15:12], p[7:4]};
    endfunction

    // Expected request for raster index c: column h asks for the pixel shown at h+1.
    function automatic req_t exp_req(geom_t g, int c);
        int ht, vt, h, v, ha, va;
        req_t r;
        ht = g.hs + g.hb + g.hv + g.hf;
        vt = g.vs + g.vb + g.vv + g.vf;
        h  = c % ht;
        v  = (c / ht) % vt;
        ha = g.hs + g.hb;
        va = g.vs + g.vb;
        r  = '0;
        if (v >= va && v < va + g.vv && h + 1 >= ha && h + 1 < ha + g.hv) begin
            r.req = 1'b1;
            r.x   = 10'(h + 1 - ha);
            r.y   = 10'(v - va);
        end
        return r;
    endfunction

    // Expected pin values registered from raster index c.
    function automatic pins_t exp_pins(geom_t g, int c, logic [23:0] key,
                                       logic use_ovr, logic [23:0] ovr_val);
        int ht, vt, h, v, ha, va;
        logic vis;
        pins_t p;
        ht  = g.hs + g.hb + g.hv + g.hf;
        vt  = g.vs + g.vb + g.vv + g.vf;
        h   = c % ht;
        v   = (c / ht) % vt;
        ha  = g.hs + g.hb;
        va  = g.vs + g.vb;
        vis = (v >= va) && (v < va + g.vv) && (h >= ha) && (h < ha + g.hv);
        p.hsync = (h >= g.hs);
        p.vsync = (v >= g.vs);
        p.de    = vis;
        if (!vis)
            p.rgb = 12'h000;
        else if (use_ovr)
            p.rgb = nibbles(ovr_val);
        else
            p.rgb = nibbles(colour(h - ha, v - va, key));
        p.fs = (h == 0) && (v == 0);
        return p;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_hsync",  64'(bus_b.hsync), 64'(1'b1));
        check_output("rst_vsync",  64'(bus_b.vsync), 64'(1'b1));
        check_output("rst_de",     64'(bus_b.de), 64'(1'b0));
        check_output("rst_rgb",    64'(bus_b.rgb), 64'(12'h000));
        check_output("rst_fs",     64'(bus_b.frame_start), 64'(1'b0));
        check_output("rst_req",    64'(bus_b.pix_req), 64'(1'b0));
        check_output("rst_pos_x",  64'(bus_b.pos_x), 64'(10'd0));
        check_output("rst_pos_y",  64'(bus_b.pos_y), 64'(10'd0));
        check_output("rst_small",
                     64'({bus_s.hsync, bus_s.vsync, bus_s.de, bus_s.rgb, bus_s.frame_start,
                          bus_s.pix_req, bus_s.pos_x, bus_s.pos_y}),
                     64'({1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 10'd0, 10'd0}));
    endtask

    // One pixel clock: check requests mid-cycle, advance, check pins, then answer as the renderers.
    task automatic apply_stimulus();
        req_t        rb, rs;
        pins_t       pb, ps;
        logic        use_ovr;
        logic [23:0] val;

        @(negedge clk);
        rb = {bus_b.pix_req, bus_b.pos_x, bus_b.pos_y};
        rs = {bus_s.pix_req, bus_s.pos_x, bus_s.pos_y};
        check_output("req_big",   64'(rb), 64'(exp_req(GB, cyc)));
        check_output("req_small", 64'(rs), 64'(exp_req(GS, cyc)));
        if (phase == 1 && cyc == ROW35 + 143) begin
            check_output("lead_req",   64'(bus_b.pix_req), 64'(1'b1));
            check_output("lead_pos_x", 64'(bus_b.pos_x), 64'(10'd0));
            check_output("lead_pos_y", 64'(bus_b.pos_y), 64'(10'd0));
        end
        if (phase == 1 && cyc == ROW35 + 782) begin
            check_output("last_req",   64'(bus_b.pix_req), 64'(1'b1));
            check_output("last_pos_x", 64'(bus_b.pos_x), 64'(10'd639));
        end
        if (phase == 1 && cyc == ROW35 + 783) begin
            check_output("after_req",   64'(bus_b.pix_req), 64'(1'b0));
            check_output("after_pos_x", 64'(bus_b.pos_x), 64'(10'd0));
        end
        if (phase == 2 && cyc % FRAME_S == 24 * LINE_S + 11) begin
            check_output("lastline_req",   64'(bus_s.pix_req), 64'(1'b1));
            check_output("lastline_pos_y", 64'(bus_s.pos_y), 64'(10'd19));
        end

        @(posedge clk);
        #1;
        cyc++;
        pb = {bus_b.hsync, bus_b.vsync, bus_b.de, bus_b.rgb, bus_b.frame_start};
        ps = {bus_s.hsync, bus_s.vsync, bus_s.de, bus_s.rgb, bus_s.frame_start};
        check_output("pins_big",   64'(pb), 64'(exp_pins(GB, cyc - 1, key_b, ovr_b, ovr_val_b)));
        check_output("pins_small", 64'(ps), 64'(exp_pins(GS, cyc - 1, key_s, 1'b0, 24'h0)));

        if (phase == 1) begin
            if (cyc - 1 == ROW35 + 144) begin
                check_output("colour_rgb", 64'(bus_b.rgb), 64'(12'hF81));
                check_output("colour_de",  64'(bus_b.de), 64'(1'b1));
            end
            if (cyc - 1 == ROW35 + 143 || cyc - 1 == ROW35 + 784) begin
                check_output("blank_rgb", 64'(bus_b.rgb), 64'(12'h000));
                check_output("blank_de",  64'(bus_b.de), 64'(1'b0));
            end
            if (prev_hs_b && !bus_b.hsync) begin
                if (n_hfall >= 1 && n_hfall <= 3)
                    check_output("hsync_period", 64'(cyc - last_hfall), 64'(LINE_B));
                last_hfall = cyc;
                n_hfall++;
            end
            if (!prev_hs_b && bus_b.hsync && n_hrise < 3) begin
                check_output("hsync_low", 64'(cyc - last_hfall), 64'(96));
                n_hrise++;
            end
            if (prev_vs_b && !bus_b.vsync)
                last_vfall_b = cyc;
            if (!prev_vs_b && bus_b.vsync && n_vrise_b == 0) begin
                check_output("vsync_low", 64'(cyc - last_vfall_b), 64'(1600));
                n_vrise_b++;
            end
            prev_hs_b = bus_b.hsync;
            prev_vs_b = bus_b.vsync;
        end

        if (phase == 2) begin
            if (prev_vs_s && !bus_s.vsync) begin
                if (n_vfall_s == 1)
                    check_output("vsync_period_s", 64'(cyc - last_vfall_s), 64'(FRAME_S));
                last_vfall_s = cyc;
                n_vfall_s++;
            end
            if (!prev_vs_s && bus_s.vsync && n_vrise_s == 0) begin
                check_output("vsync_low_s", 64'(cyc - last_vfall_s), 64'(2 * LINE_S));
                n_vrise_s++;
            end
            prev_vs_s = bus_s.vsync;
            if (bus_s.frame_start) begin
                fs_cnt++;
                fs_times.push_back(cyc);
            end
            if (bus_s.de && cyc <= 2 * FRAME_S)
                de_cnt[(cyc - 1) / FRAME_S]++;
        end

        use_ovr = 1'b0;
        val     = 24'h0;
        if (phase == 1 && cyc == ROW35 + 144) begin
            use_ovr = 1'b1;
            val     = 24'hFF8010;
        end else if (phase == 1 && (cyc == ROW35 + 143 || cyc == ROW35 + 784)) begin
            use_ovr = 1'b1;
            val     = 24'hFFFFFF;
        end
        ovr_b     = use_ovr;
        ovr_val_b = val;
        bus_b.pos_data = use_ovr ? val
                       : (rb.req ? colour(int'(rb.x), int'(rb.y), key_b) : 24'($urandom));
        bus_s.pos_data = rs.req ? colour(int'(rs.x), int'(rs.y), key_s) : 24'($urandom);
    endtask

    initial begin
        int gap;
        rst            = 1'b1;
        bus_b.pos_data = 24'h0;
        bus_s.pos_data = 24'h0;
        key_b          = 24'($urandom);
        key_s          = 24'($urandom);
        ovr_b          = 1'b0;
        ovr_val_b      = 24'h0;
        prev_hs_b      = 1'b1;
        prev_vs_b      = 1'b1;
        prev_vs_s      = 1'b1;
        last_hfall     = 0;
        n_hfall        = 0;
        n_hrise        = 0;
        last_vfall_b   = 0;
        n_vrise_b      = 0;
        last_vfall_s   = 0;
        n_vfall_s      = 0;
        n_vrise_s      = 0;
        fs_cnt         = 0;
        de_cnt[0]      = 0;
        de_cnt[1]      = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values();

        rst            = 1'b0;
        cyc            = 0;
        phase          = 1;
        bus_b.pos_data = 24'($urandom);
        bus_s.pos_data = 24'($urandom);
        apply_stimulus();
        check_output("first_hsync", 64'(bus_b.hsync), 64'(1'b0));
        check_output("first_vsync", 64'(bus_b.vsync), 64'(1'b0));
        check_output("first_fs",    64'(bus_b.frame_start), 64'(1'b1));

        while (cyc < 36 * LINE_B + 10)
            apply_stimulus();
        while (cyc % LINE_B != 400)
            apply_stimulus();

        rst = 1'b1;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();

        rst            = 1'b0;
        cyc            = 0;
        phase          = 2;
        key_b          = 24'($urandom);
        key_s          = 24'($urandom);
        ovr_b          = 1'b0;
        prev_vs_s      = 1'b1;
        bus_b.pos_data = 24'($urandom);
        bus_s.pos_data = 24'($urandom);
        apply_stimulus();
        check_output("rerun_hsync",    64'(bus_b.hsync), 64'(1'b0));
        check_output("rerun_vsync",    64'(bus_b.vsync), 64'(1'b0));
        check_output("rerun_fs",       64'(bus_b.frame_start), 64'(1'b1));
        check_output("rerun_fs_small", 64'(bus_s.frame_start), 64'(1'b1));

        while (cyc < 2 * FRAME_S)
            apply_stimulus();

        gap = (fs_times.size() >= 2) ? fs_times[1] - fs_times[0] : -1;
        check_output("fs_count",   64'(fs_cnt), 64'(2));
        check_output("fs_spacing", 64'(gap), 64'(FRAME_S));
        check_output("de_frame0",  64'(de_cnt[0]), 64'(32 * 20));
        check_output("de_frame1",  64'(de_cnt[1]), 64'(32 * 20));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
